// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline.
// Generates load-use stalls, branch/jump/interrupt flushes, EX forwarding selects and perf counters.
module hazard_ctrl #(
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs_ID,
   input  logic [4:0]       rt_ID,
   input  logic             use_rs_ID,
   input  logic             use_rt_ID,
   input  logic             jump_ID,
   input  logic [4:0]       rs_EX,
   input  logic [4:0]       rt_EX,
   input  logic             MemRead_EX,
   input  logic             RegWrite_EX,
   input  logic [4:0]       Write_register_EX,
   input  logic             branch_taken_EX,
   input  logic             RegWrite_MEM,
   input  logic [4:0]       Write_register_MEM,
   input  logic             RegWrite_WB,
   input  logic [4:0]       Write_register_WB,
   input  logic             irq,
   input  logic             irq_en,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IFFlush,
   output logic             IDEXBubble,
   output logic             irq_take,
   output logic [1:0]       ForwardA,
   output logic [1:0]       ForwardB,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [1:0]       state_dbg
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_STALL = 2'd1;
   localparam logic [1:0] S_IRQ   = 2'd2;

   localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL - 1);

   logic [1:0] state, state_nxt;
   logic [2:0] stall_left, stall_left_nxt;
   logic       irq_pending;
   logic       load_use_hit;
   logic       stall_inc;
   logic       flush_inc;
   logic       reg_write_ex_unused;

   // RegWrite_EX is not needed: a load always writes, and MemRead_EX identifies it.
   assign reg_write_ex_unused = RegWrite_EX;

   assign load_use_hit = MemRead_EX && (Write_register_EX != 5'd0) &&
                         ((use_rs_ID && (rs_ID == Write_register_EX)) ||
                          (use_rt_ID && (rt_ID == Write_register_EX)));

   assign state_dbg = state;

   always_comb begin
      PCWrite        = 1'b1;
      IFIDWrite      = 1'b1;
      IFFlush        = 1'b0;
      IDEXBubble     = 1'b0;
      irq_take       = 1'b0;
      ForwardA       = 2'b00;
      ForwardB       = 2'b00;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;
      state_nxt      = state;
      stall_left_nxt = stall_left;
      // Reset is folded in so outputs fall back to idle values without waiting for a clock.
      if (reset) begin
         if (RegWrite_MEM && (Write_register_MEM != 5'd0) && (Write_register_MEM == rs_EX))
            ForwardA = 2'b10;
         else if (RegWrite_WB && (Write_register_WB != 5'd0) && (Write_register_WB == rs_EX))
            ForwardA = 2'b01;
         if (RegWrite_MEM && (Write_register_MEM != 5'd0) && (Write_register_MEM == rt_EX))
            ForwardB = 2'b10;
         else if (RegWrite_WB && (Write_register_WB != 5'd0) && (Write_register_WB == rt_EX))
            ForwardB = 2'b01;

         case (state)
            S_IDLE: begin
               if (branch_taken_EX) begin
                  IFFlush    = 1'b1;
                  IDEXBubble = 1'b1;
                  flush_inc  = 1'b1;
               end else if (load_use_hit) begin
                  PCWrite    = 1'b0;
                  IFIDWrite  = 1'b0;
                  IDEXBubble = 1'b1;
                  stall_inc  = 1'b1;
                  if (LOAD_STALL > 1) begin
                     state_nxt      = S_STALL;
                     stall_left_nxt = STALL_INIT;
                  end
               end else if (irq_pending && irq_en) begin
                  irq_take   = 1'b1;
                  IFFlush    = 1'b1;
                  IDEXBubble = 1'b1;
                  flush_inc  = 1'b1;
                  state_nxt  = S_IRQ;
               end else if (jump_ID) begin
                  IFFlush   = 1'b1;
                  flush_inc = 1'b1;
               end
            end
            S_STALL: begin
               PCWrite        = 1'b0;
               IFIDWrite      = 1'b0;
               IDEXBubble     = 1'b1;
               stall_inc      = 1'b1;
               stall_left_nxt = stall_left - 3'd1;
               if (stall_left <= 3'd1) state_nxt = S_IDLE;
            end
            S_IRQ: begin
               state_nxt = S_IDLE;
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         stall_left <= 3'd0;
      end else begin
         state      <= state_nxt;
         stall_left <= stall_left_nxt;
      end
   end

   // A new request in the same cycle as the take keeps the interrupt pending.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        irq_pending <= 1'b0;
      else if (irq)      irq_pending <= 1'b1;
      else if (irq_take) irq_pending <= 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one LOAD_STALL=1/CNT_W=4 instance and one LOAD_STALL=3/CNT_W=16
// instance share stimulus; expected {state, controls, counters} words go through per-instance queues.
module tb_hazard_ctrl;

   localparam logic [8:0] C_IDLE  = 9'b110000000;
   localparam logic [8:0] C_STALL = 9'b000100000;
   localparam logic [8:0] C_BR    = 9'b111100000;
   localparam logic [8:0] C_JMP   = 9'b111000000;
   localparam logic [8:0] C_TAKE  = 9'b111110000;

   logic clk = 1'b0;
   logic reset;
   logic [4:0] rs_ID, rt_ID, rs_EX, rt_EX;
   logic use_rs_ID, use_rt_ID, jump_ID;
   logic MemRead_EX, RegWrite_EX, branch_taken_EX;
   logic [4:0] Write_register_EX, Write_register_MEM, Write_register_WB;
   logic RegWrite_MEM, RegWrite_WB, irq, irq_en;

   logic pcw1, ifw1, iff1, bub1, take1;
   logic [1:0] fa1, fb1, st1;
   logic [3:0] sc1, fc1;
   logic pcw3, ifw3, iff3, bub3, take3;
   logic [1:0] fa3, fb3, st3;
   logic [15:0] sc3, fc3;

   logic [42:0] exp1_q[$];
   logic [42:0] exp3_q[$];
   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.LOAD_STALL(1), .CNT_W(4)) u1 (
      .clk(clk), .reset(reset), .rs_ID(rs_ID), .rt_ID(rt_ID),
      .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID), .jump_ID(jump_ID),
      .rs_EX(rs_EX), .rt_EX(rt_EX), .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX),
      .Write_register_EX(Write_register_EX), .branch_taken_EX(branch_taken_EX),
      .RegWrite_MEM(RegWrite_MEM), .Write_register_MEM(Write_register_MEM),
      .RegWrite_WB(RegWrite_WB), .Write_register_WB(Write_register_WB),
      .irq(irq), .irq_en(irq_en), .PCWrite(pcw1), .IFIDWrite(ifw1), .IFFlush(iff1),
      .IDEXBubble(bub1), .irq_take(take1), .ForwardA(fa1), .ForwardB(fb1),
      .stall_cnt(sc1), .flush_cnt(fc1), .state_dbg(st1)
   );

   hazard_ctrl #(.LOAD_STALL(3), .CNT_W(16)) u3 (
      .clk(clk), .reset(reset), .rs_ID(rs_ID), .rt_ID(rt_ID),
      .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID), .jump_ID(jump_ID),
      .rs_EX(rs_EX), .rt_EX(rt_EX), .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX),
      .Write_register_EX(Write_register_EX), .branch_taken_EX(branch_taken_EX),
      .RegWrite_MEM(RegWrite_MEM), .Write_register_MEM(Write_register_MEM),
      .RegWrite_WB(RegWrite_WB), .Write_register_WB(Write_register_WB),
      .irq(irq), .irq_en(irq_en), .PCWrite(pcw3), .IFIDWrite(ifw3), .IFFlush(iff3),
      .IDEXBubble(bub3), .irq_take(take3), .ForwardA(fa3), .ForwardB(fb3),
      .stall_cnt(sc3), .flush_cnt(fc3), .state_dbg(st3)
   );

   function automatic logic [42:0] w(logic [1:0] st, logic [8:0] c, int sc, int fc);
      return {st, c, 16'(sc), 16'(fc)};
   endfunction

   task automatic push(logic [42:0] e1, logic [42:0] e3);
      exp1_q.push_back(e1);
      exp3_q.push_back(e3);
   endtask

   task automatic sample(string tag);
      logic [42:0] o1, o3, e1, e3;
      o1 = {st1, pcw1, ifw1, iff1, bub1, take1, fa1, fb1, 12'd0, sc1, 12'd0, fc1};
      o3 = {st3, pcw3, ifw3, iff3, bub3, take3, fa3, fb3, sc3, fc3};
      e1 = exp1_q.pop_front();
      e3 = exp3_q.pop_front();
      tests_run++;
      assert (o1 === e1) else begin
         tests_failed++;
         $error("FAIL %s ls1: observed %h expected %h", tag, o1, e1);
      end
      tests_run++;
      assert (o3 === e3) else begin
         tests_failed++;
         $error("FAIL %s ls3: observed %h expected %h", tag, o3, e3);
      end
   endtask

   task automatic cyc(logic [42:0] e1, logic [42:0] e3, string tag);
      push(e1, e3);
      @(negedge clk);
      sample(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int f1;
      reset = 1'b0;
      rs_ID = 0; rt_ID = 0; use_rs_ID = 0; use_rt_ID = 0; jump_ID = 0;
      rs_EX = 0; rt_EX = 0; MemRead_EX = 0; RegWrite_EX = 0; branch_taken_EX = 0;
      Write_register_EX = 0; Write_register_MEM = 0; Write_register_WB = 0;
      RegWrite_MEM = 0; RegWrite_WB = 0; irq = 0; irq_en = 0;

      repeat (2) @(posedge clk);
      push(w(0, C_IDLE, 0, 0), w(0, C_IDLE, 0, 0));
      @(negedge clk);
      sample("reset");
      reset = 1'b1;
      @(posedge clk);
      #1;

      // lw $8 followed by a dependent add
      MemRead_EX = 1; RegWrite_EX = 1; Write_register_EX = 8; rs_ID = 8; use_rs_ID = 1;
      cyc(w(0, C_STALL, 0, 0), w(0, C_STALL, 0, 0), "lu_first");
      MemRead_EX = 0; RegWrite_EX = 0;
      cyc(w(0, C_IDLE, 1, 0), w(1, C_STALL, 1, 0), "lu_second");
      cyc(w(0, C_IDLE, 1, 0), w(1, C_STALL, 2, 0), "lu_third");
      cyc(w(0, C_IDLE, 1, 0), w(0, C_IDLE, 3, 0), "lu_done");

      // load to $0 never stalls; an unused rt never stalls
      MemRead_EX = 1; Write_register_EX = 0; rs_ID = 0;
      cyc(w(0, C_IDLE, 1, 0), w(0, C_IDLE, 3, 0), "lu_r0");
      Write_register_EX = 9; rs_ID = 3; rt_ID = 9; use_rt_ID = 0;
      cyc(w(0, C_IDLE, 1, 0), w(0, C_IDLE, 3, 0), "lu_rt_unused");
      use_rt_ID = 1;
      cyc(w(0, C_STALL, 1, 0), w(0, C_STALL, 3, 0), "lu_rt_used");
      // jump held in ID while the long stall drains
      MemRead_EX = 0; jump_ID = 1;
      cyc(w(0, C_JMP, 2, 0), w(1, C_STALL, 4, 0), "jmp_in_stall_a");
      cyc(w(0, C_JMP, 2, 1), w(1, C_STALL, 5, 0), "jmp_in_stall_b");
      cyc(w(0, C_JMP, 2, 2), w(0, C_JMP, 6, 0), "jmp_after_stall");
      jump_ID = 0; use_rt_ID = 0;
      cyc(w(0, C_IDLE, 2, 3), w(0, C_IDLE, 6, 1), "jmp_count");

      // branch beats load-use and jump
      MemRead_EX = 1; Write_register_EX = 8; rs_ID = 8; use_rs_ID = 1; jump_ID = 1;
      branch_taken_EX = 1;
      cyc(w(0, C_BR, 2, 3), w(0, C_BR, 6, 1), "branch_prio");
      MemRead_EX = 0; jump_ID = 0; branch_taken_EX = 0; use_rs_ID = 0;
      cyc(w(0, C_IDLE, 2, 4), w(0, C_IDLE, 6, 2), "branch_count");

      // forwarding
      RegWrite_MEM = 1; Write_register_MEM = 5; RegWrite_WB = 1; Write_register_WB = 5;
      rs_EX = 5; rt_EX = 0;
      cyc(w(0, 9'b110001000, 2, 4), w(0, 9'b110001000, 6, 2), "fwd_mem_prio");
      RegWrite_MEM = 0;
      cyc(w(0, 9'b110000100, 2, 4), w(0, 9'b110000100, 6, 2), "fwd_wb");
      RegWrite_MEM = 1; rt_EX = 5;
      cyc(w(0, 9'b110001010, 2, 4), w(0, 9'b110001010, 6, 2), "fwd_both_mem");
      Write_register_MEM = 0; Write_register_WB = 0; rs_EX = 0; rt_EX = 0;
      cyc(w(0, C_IDLE, 2, 4), w(0, C_IDLE, 6, 2), "fwd_r0");
      RegWrite_MEM = 0; RegWrite_WB = 0;

      // interrupt latched while disabled, taken once enabled
      irq = 1;
      cyc(w(0, C_IDLE, 2, 4), w(0, C_IDLE, 6, 2), "irq_pulse");
      irq = 0;
      for (int i = 0; i < 4; i++)
         cyc(w(0, C_IDLE, 2, 4), w(0, C_IDLE, 6, 2), "irq_disabled");
      irq_en = 1;
      cyc(w(0, C_TAKE, 2, 4), w(0, C_TAKE, 6, 2), "irq_take");
      cyc(w(2, C_IDLE, 2, 5), w(2, C_IDLE, 6, 3), "irq_state");
      cyc(w(0, C_IDLE, 2, 5), w(0, C_IDLE, 6, 3), "irq_no_retake");
      irq_en = 0;

      // flush counter saturation (4-bit instance)
      jump_ID = 1;
      for (int i = 0; i < 12; i++) begin
         f1 = (5 + i > 15) ? 15 : 5 + i;
         cyc(w(0, C_JMP, 2, f1), w(0, C_JMP, 6, 3 + i), "sat_jump");
      end
      jump_ID = 0;
      cyc(w(0, C_IDLE, 2, 15), w(0, C_IDLE, 6, 15), "sat_hold");

      // asynchronous reset in the middle of a stall
      MemRead_EX = 1; Write_register_EX = 8; rs_ID = 8; use_rs_ID = 1;
      cyc(w(0, C_STALL, 2, 15), w(0, C_STALL, 6, 15), "pre_rst_stall");
      push(w(0, C_STALL, 3, 15), w(1, C_STALL, 7, 15));
      @(negedge clk);
      sample("in_stall");
      reset = 1'b0;
      #1;
      push(w(0, C_IDLE, 0, 0), w(0, C_IDLE, 0, 0));
      sample("async_reset");
      @(posedge clk);
      #1;
      reset = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Feedback-path controller for the 5-stage pipeline: reads destination/control fields from the ID/EX, EX/MEM and MEM/WB registers and drives stall, flush and forwarding controls back toward PC, IF/ID and ID/EX.
- Owns the load-use stall FSM, branch/jump flush, interrupt take sequencing, and saturating stall/flush performance counters.
- Sits beside the pipeline registers; its outputs feed PC write-enable, the IFFlush input of the IF/ID register, the bubble control of ID/EX and the EX-stage operand muxes.

Parameters:
- LOAD_STALL, 1, bubble cycles per load-use hazard (1..7).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low
- rs_ID, rt_ID  in  5 each  source registers of the instruction in ID
- use_rs_ID, use_rt_ID  in  1 each  ID instruction reads rs/rt
- jump_ID  in  1  j/jal/jr/jalr decoded in ID
- rs_EX, rt_EX  in  5 each  source registers of the instruction in EX
- MemRead_EX, RegWrite_EX  in  1 each
- Write_register_EX  in  5
- branch_taken_EX  in  1  branch resolved taken in EX
- RegWrite_MEM  in  1;  Write_register_MEM  in  5
- RegWrite_WB  in  1;  Write_register_WB  in  5
- irq  in  1  external interrupt, level
- irq_en  in  1  interrupts enabled
- PCWrite  out  1  PC may update
- IFIDWrite  out  1  IF/ID may load
- IFFlush  out  1  clear IF/ID
- IDEXBubble  out  1  load zeros into ID/EX control fields
- irq_take  out  1  one-cycle pulse: redirect to handler this cycle
- ForwardA, ForwardB  out  2 each  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters

Behaviour:
- Reset (reset=0, async): state=IDLE, stall counter=0, irq_pending=0, stall_cnt=flush_cnt=0. Outputs: PCWrite=1, IFIDWrite=1, IFFlush=0, IDEXBubble=0, irq_take=0, ForwardA=ForwardB=00. Reset mid-stall aborts to IDLE.
- Forwarding (combinational): ForwardA=10 if RegWrite_MEM && Write_register_MEM!=0 && Write_register_MEM==rs_EX; else 01 if RegWrite_WB && Write_register_WB!=0 && Write_register_WB==rs_EX; else 00. ForwardB identical using rt_EX. MEM has priority over WB.
- Load-use hit: MemRead_EX && Write_register_EX!=0 && ((use_rs_ID && rs_ID==Write_register_EX) || (use_rt_ID && rt_ID==Write_register_EX)).
- FSM states: IDLE, STALL, IRQ.
- IDLE, priority order:
  1. branch_taken_EX: IFFlush=1, IDEXBubble=1, PCWrite=1; flush_cnt++. This overrides a load-use hit and a jump in the same cycle.
  2. Load-use hit: PCWrite=0, IFIDWrite=0, IDEXBubble=1; stall_cnt++. If LOAD_STALL>1, go to STALL with the counter loaded to LOAD_STALL-1.
  3. irq_pending && irq_en: irq_take=1, IFFlush=1, IDEXBubble=1, clear irq_pending; flush_cnt++; go to IRQ.
  4. jump_ID: IFFlush=1; flush_cnt++.
- STALL: hold PCWrite=0, IFIDWrite=0, IDEXBubble=1; stall_cnt++ each cycle; decrement the counter; return to IDLE when it reaches 0. branch_taken_EX cannot occur here because EX holds a bubble. A jump held in ID flushes only after the stall ends.
- IRQ: exactly one cycle with all controls at idle values (lets the redirect settle); then IDLE.
- irq_pending: set on any clk edge with irq=1; cleared only at irq_take. Set has priority over clear in the same cycle.
- Counters: stop at all-ones with no wrap. An increment and saturation in the same cycle holds all-ones.

Test Plan:
- lw $8 in EX (MemRead_EX=1, Write_register_EX=8), ID add with rs_ID=8, use_rs_ID=1 -> one cycle PCWrite=0, IFIDWrite=0, IDEXBubble=1; stall_cnt 0->1. With LOAD_STALL=3 -> 3 stall cycles; stall_cnt=3.
- Load-use hit with Write_register_EX=0 -> no stall. Hit with use_rt_ID=0 and only rt_ID matching -> no stall.
- branch_taken_EX=1 together with a load-use hit and jump_ID=1 -> IFFlush=1, IDEXBubble=1, PCWrite=1; stall_cnt unchanged; flush_cnt +1.
- RegWrite_MEM=1, Write_register_MEM=5 and RegWrite_WB=1, Write_register_WB=5 with rs_EX=5 -> ForwardA=10. With RegWrite_MEM=0 -> ForwardA=01. With rt_EX=0 -> ForwardB=00.
- irq pulsed for one cycle, irq_en=0 for 4 cycles, then irq_en=1 -> irq_take single pulse on the first idle cycle after enable, with IFFlush=1. The next cycle is the IRQ state with idle controls. No second take.
- Preload flush_cnt near all-ones, drive repeated jump_ID -> flush_cnt stops at all-ones (0xFFFF for CNT_W=16). Assert reset during STALL -> outputs return to reset values immediately, without waiting for a clock edge.
